inv_key_schedule: RTL and testbench
===================================

Name: inv_key_schedule

Overview:
- Reverse-direction AES-128 key expander for the decryption datapath.
- Loaded once with the round-10 key, it emits round keys 10, 9, …, 0 in descending order over a valid/ready handshake.
- Each previous round key is rebuilt with the inverse recurrence, using one time-multiplexed S-box. This is the counterpart of the forward per-round KeySchedule.

Parameters:
- NUM_ROUNDS, 10: number of rounds; it sets the first value of Round_o.
- RCON_LAST, 8'h36: Rcon used to undo the final round.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  1-cycle pulse; load RoundKey_i. Ignored unless the block is idle.
- RoundKey_i  in  128  round-10 key, same byte packing as Key_o.
- Key_o  out  128  current round key. Byte index 4*row+col holds state[row][col]; column c is word w_c.
- Key_flag  out  1  Key_o/Round_o valid.
- Key_ready  in  1  consumer accepts when Key_flag && Key_ready.
- Round_o  out  4  round number of Key_o (10 down to 0).
- Busy  out  1  high from the cycle after start until the round-0 key is accepted.
- Done_flag  out  1  1-cycle pulse after the round-0 key is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - Key_o, Round_o, Key_flag, Busy and Done_flag all go to 0.
  - Internal key, temp word T and Rcon are cleared.
  - Reset mid-operation aborts with no output glitch beyond going to 0.
- FSM states: IDLE, EMIT, SUB0, SUB1, SUB2, SUB3, UPD.
- IDLE:
  - On start: Key_o<=RoundKey_i, Round_o<=NUM_ROUNDS, Rcon<=RCON_LAST, go to EMIT.
  - Key_flag rises the cycle after start (latency 1).
- EMIT:
  - Key_flag=1; Key_o and Round_o are held stable until acceptance.
  - On acceptance with Round_o==0: go to IDLE; Busy drops and Done_flag=1 in the next cycle.
  - On acceptance with Round_o!=0: go to SUB0; Key_flag drops the next cycle.
- SUB0..SUB3:
  - P3 = w3 ^ w2, formed combinationally from the current key.
  - SUBj writes T[row j] <= Sbox(P3[row (j+1) mod 4]), which is RotWord then SubWord.
  - One S-box lookup per cycle.
- UPD:
  - New words: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - w0' = w0 ^ T ^ {Rcon in row 0, 0, 0, 0}.
  - Key_o<=new key, Round_o<=Round_o-1, Rcon<=inv_xtime(Rcon); go to EMIT.
- inv_xtime: 8'h1b→8'h80, else Rcon>>1. Sequence: 36,1b,80,40,20,10,08,04,02,01.
- Timing: acceptance edge to the next Key_flag is 5 SUB/UPD cycles, so Key_flag is high in the 6th cycle after acceptance. With Key_ready tied high, Key_flag is a 1-cycle pulse every 6 cycles.
- start while Busy: ignored, with no effect on state.
- Key_ready asserted while Key_flag=0: ignored.

Decomposition:
- aes_pkg holds:
  - FSM state enum.
  - NUM_ROUNDS and RCON_LAST constants.
  - inv_xtime function.
  - Byte-index helper for the row/column packing.
- One sub-module: aes_sbox, a combinational 8-bit forward S-box LUT shared with KeySchedule. It is instantiated once here.

Test Plan:
- FIPS-197 round 10: start with RoundKey_i=128'ha6c889a80c0c25f9633fee14b6e1c9d0 and Key_ready=1.
  - Required sequence: round 10 = input.
  - Round 9 = 128'h6e4121f30029dc665cd1fa77572819ac.
  - Round 1 = 128'h0539b11776392cfe6ca354fa2a2388a0.
  - Round 0 = 128'h3c88a6164f15d215cff7ae7e09ab282b.
  - Done_flag pulses once.
- Backpressure: hold Key_ready=0 for 20 cycles while round 9 is presented.
  - Key_o stays 128'h6e41…19ac, Round_o stays 9, Key_flag stays 1.
  - Round 8 appears 6 cycles after Key_ready goes high.
- Throughput with Key_ready=1: Key_flag pulses exactly 11 times, 6 cycles apart. Done_flag fires 1 cycle after the round-0 acceptance. Busy is high throughout.
- Start pulsed at round 6 with a different RoundKey_i: ignored; the remaining keys still match the FIPS sequence.
- rst_n low while at round 5 (asynchronously, mid-SUB2):
  - Every output reads 0 immediately.
  - After release, a new start with the FIPS round-10 key reproduces the full sequence correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, constants and helpers
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_SUB0,
        ST_SUB1,
        ST_SUB2,
        ST_SUB3,
        ST_UPD
    } state_e;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam logic [7:0] AES_RCON_LAST  = 8'h36;

    // Inverse of the Rcon doubling step; 1b wraps back to 80.
    function automatic logic [7:0] inv_xtime(input logic [7:0] rc);
        return (rc == 8'h1b) ? 8'h80 : (rc >> 1);
    endfunction

    // Byte position of state[row][col] inside a packed 128-bit key.
    function automatic int byte_idx(input int row, input int col);
        return 4 * row + col;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// rtl/inv_key_schedule_if.sv - round-key output stream with valid/ready handshake
interface inv_key_schedule_if;
    logic [127:0] Key_o;
    logic         Key_flag;
    logic         Key_ready;
    logic [3:0]   Round_o;

    modport master (output Key_o, output Key_flag, output Round_o, input Key_ready);
    modport slave  (input Key_o, input Key_flag, input Round_o, output Key_ready);
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup table
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = SBOX[data_i];
endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - reverse AES-128 key expander emitting round keys 10 down to 0
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int         NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter logic [7:0] RCON_LAST  = AES_RCON_LAST
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [127:0]                RoundKey_i,
    inv_key_schedule_if.master          key_if,
    output logic                        Busy,
    output logic                        Done_flag
);

    state_e          state_q, state_d;
    logic [127:0]    key_q, key_d;
    logic [3:0][7:0] t_q, t_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [3:0]      round_q, round_d;
    logic            done_q, done_d;

    logic            load, sub_en, upd;
    logic [1:0]      sub_row;
    logic [1:0]      src_row;
    logic [3:0][7:0] p3;
    logic [127:0]    key_prev;
    logic [7:0]      sbox_in, sbox_out;
    logic            accept;

    assign key_if.Key_o    = key_q;
    assign key_if.Round_o  = round_q;
    assign key_if.Key_flag = (state_q == ST_EMIT);
    assign Busy            = (state_q != ST_IDLE);
    assign Done_flag       = done_q;
    assign accept          = key_if.Key_flag && key_if.Key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sub_en  = 1'b0;
        sub_row = 2'd0;
        upd     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    if (round_q == 4'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SUB0;
                    end
                end
            end
            ST_SUB0: begin sub_en = 1'b1; sub_row = 2'd0; state_d = ST_SUB1; end
            ST_SUB1: begin sub_en = 1'b1; sub_row = 2'd1; state_d = ST_SUB2; end
            ST_SUB2: begin sub_en = 1'b1; sub_row = 2'd2; state_d = ST_SUB3; end
            ST_SUB3: begin sub_en = 1'b1; sub_row = 2'd3; state_d = ST_UPD;  end
            ST_UPD: begin
                upd     = 1'b1;
                state_d = ST_EMIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // P3 is the previous round's w3; RotWord makes row j read row j+1.
    always_comb begin
        p3 = '0;
        for (int r = 0; r < 4; r++) begin
            p3[r] = key_q[8*byte_idx(r, 3) +: 8] ^ key_q[8*byte_idx(r, 2) +: 8];
        end
    end

    assign src_row = sub_row + 2'd1;
    assign sbox_in = p3[src_row];

    aes_sbox u_sbox (
        .data_i (sbox_in),
        .data_o (sbox_out)
    );

    always_comb begin
        key_prev = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 1; c < 4; c++) begin
                key_prev[8*byte_idx(r, c) +: 8] =
                    key_q[8*byte_idx(r, c) +: 8] ^ key_q[8*byte_idx(r, c - 1) +: 8];
            end
            key_prev[8*byte_idx(r, 0) +: 8] = key_q[8*byte_idx(r, 0) +: 8] ^ t_q[r]
                                              ^ ((r == 0) ? rcon_q : 8'h00);
        end
    end

    always_comb begin
        key_d   = key_q;
        t_d     = t_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        if (load) begin
            key_d   = RoundKey_i;
            round_d = 4'(NUM_ROUNDS);
            rcon_d  = RCON_LAST;
        end else if (sub_en) begin
            t_d[sub_row] = sbox_out;
        end else if (upd) begin
            key_d   = key_prev;
            round_d = round_q - 4'd1;
            rcon_d  = inv_xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            t_q     <= '0;
            rcon_q  <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            t_q     <= t_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - scoreboard bench for the reverse AES-128 key expander
module tb_inv_key_schedule;

    localparam logic [127:0] FIPS_R10 = 128'ha6c889a80c0c25f9633fee14b6e1c9d0;
    localparam logic [127:0] FIPS_R9  = 128'h6e4121f30029dc665cd1fa77572819ac;
    localparam logic [127:0] FIPS_R1  = 128'h0539b11776392cfe6ca354fa2a2388a0;
    localparam logic [127:0] FIPS_R0  = 128'h3c88a6164f15d215cff7ae7e09ab282b;
    localparam logic [127:0] OTHER_KEY = 128'h0123456789abcdeffedcba9876543210;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] round_key;
    logic         busy;
    logic         done_flag;

    inv_key_schedule_if kif ();

    inv_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .RoundKey_i (round_key),
        .key_if     (kif),
        .Busy       (busy),
        .Done_flag  (done_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t sb[$];
    logic [7:0]   sbox_tab [256];
    logic [127:0] model_keys [11];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box built from the GF(2^8) inverse and affine map, independent of the RTL table.
    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] bb = 8'(b);
            for (int x = 1; x < 256; x++) begin
                if (bb != 8'h00 && gmul(bb, 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward FIPS-197 expansion of the cipher key, packed byte 4*row+col.
    task automatic build_model();
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        w[0] = 32'h2b7e1516; w[1] = 32'h28aed2a6; w[2] = 32'habf71588; w[3] = 32'h09cf4f3c;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    model_keys[r][8*(4*row+c) +: 8] = w[4*r+c][31-8*row -: 8];
                end
            end
        end
    endtask

    task automatic wait_flag(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (kif.Key_flag) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key"},   kif.Key_o, 128'h0);
        check({tag, "_round"}, 128'(kif.Round_o), 128'h0);
        check({tag, "_flag"},  128'(kif.Key_flag), 128'h0);
        check({tag, "_busy"},  128'(busy), 128'h0);
        check({tag, "_done"},  128'(done_flag), 128'h0);
    endtask

    task automatic run_keys(input int stall_rnd, input int ign_rnd, input int abort_rnd);
        exp_t e;
        bit   ok;
        int   prev_cyc = -1;
        int   quiet = 0;
        @(negedge clk);
        round_key = FIPS_R10;
        start = 1'b1;
        for (int r = 10; r >= 0; r--) sb.push_back('{rnd: 4'(r), key: model_keys[r]});
        @(negedge clk);
        start = 1'b0;
        check("start_latency", 128'(kif.Key_flag), 128'h1);
        for (int r = 10; r >= 0; r--) begin
            wait_flag(ok);
            if (!ok) begin
                check("flag_timeout", 128'h0, 128'h1);
                sb.delete();
                return;
            end
            e = sb.pop_front();
            check("round", 128'(kif.Round_o), 128'(e.rnd));
            check("key", kif.Key_o, e.key);
            check("busy_high", 128'(busy), 128'h1);
            if (prev_cyc >= 0) check("interval", 128'(cyc - prev_cyc), 128'd6);
            case (r)
                9: check("fips_r9", kif.Key_o, FIPS_R9);
                1: check("fips_r1", kif.Key_o, FIPS_R1);
                0: check("fips_r0", kif.Key_o, FIPS_R0);
                default: ;
            endcase
            if (r == stall_rnd) begin
                kif.Key_ready = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    check("stall_key", kif.Key_o, e.key);
                    check("stall_round", 128'(kif.Round_o), 128'(e.rnd));
                    check("stall_flag", 128'(kif.Key_flag), 128'h1);
                end
                kif.Key_ready = 1'b1;
            end
            prev_cyc = cyc;
            if (r == ign_rnd) begin
                round_key = OTHER_KEY;
                start = 1'b1;
            end
            if (r == abort_rnd) begin
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_all_zero("async_rst");
                sb.delete();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_all_zero("post_rst");
                return;
            end
            @(negedge clk);
            start = 1'b0;
            round_key = FIPS_R10;
            check("flag_drop", 128'(kif.Key_flag), 128'h0);
            if (r == 0) begin
                check("done_pulse", 128'(done_flag), 128'h1);
                check("busy_low", 128'(busy), 128'h0);
                @(negedge clk);
                check("done_clear", 128'(done_flag), 128'h0);
            end
        end
        check("sb_empty", 128'(sb.size()), 128'h0);
        repeat (12) begin
            @(negedge clk);
            if (kif.Key_flag || done_flag || busy) quiet++;
        end
        check("idle_quiet", 128'(quiet), 128'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        round_key = '0;
        kif.Key_ready = 1'b1;
        build_sbox();
        build_model();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");
        run_keys(-1, -1, -1);
        run_keys(9, 6, -1);
        run_keys(-1, -1, 5);
        run_keys(-1, -1, -1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
